switch_buttons_in: RTL and testbench

- Memory-mapped input peripheral; the read-side counterpart of the LED output device on the same device/command/perf_en bus.
- Synchronises and debounces 8 slide switches and 5 push buttons.
- Latches button press events.
- Returns switch, button or event data to the CPU on a registered 32-bit data_out with a one-cycle valid strobe.

---
 rtl/switch_buttons_in.sv | 108 ++++++++++
 tb/tb_switch_buttons_in.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_buttons_in.sv
// Switch/button input peripheral: sync, debounce, press-event latch, bus reads.
// Define SWITCH_BUTTONS_IRQ_EN to add a registered irq output for pending events.
module switch_buttons_in #(
  parameter logic [4:0] DEV_ID          = 5'b00001,
  parameter int         DEBOUNCE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        perf_en,
  input  logic [4:0]  device,
  input  logic [5:0]  command,
  input  logic [7:0]  switches,
  input  logic [4:0]  buttons,
  output logic [31:0] data_out,
  output logic        data_valid
`ifdef SWITCH_BUTTONS_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [5:0] READ_SW  = 6'b000010;
  localparam logic [5:0] READ_BTN = 6'b000011;
  localparam logic [5:0] READ_EVT = 6'b000100;

  // bits [7:0] are switches, [12:8] are buttons
  logic [12:0]   raw;
  logic [12:0]   s1;
  logic [12:0]   s2;
  logic [12:0]   stable;
  logic [12:0]   stable_next;
  logic [CW-1:0] cnt [13];
  logic [CW-1:0] cnt_next [13];

  logic [4:0]  evt;
  logic [4:0]  evt_next;
  logic [4:0]  rise;
  logic        addressed;
  logic        is_sw;
  logic        is_btn;
  logic        is_evt;
  logic        hit;
  logic [31:0] rd_data;

  assign raw = {buttons, switches};

  always_comb begin
    for (int i = 0; i < 13; i++) begin
      stable_next[i] = stable[i];
      cnt_next[i]    = '0;
      if (s2[i] != stable[i]) begin
        if (cnt[i] == CMAX) stable_next[i] = s2[i];
        else cnt_next[i] = cnt[i] + CW'(1);
      end
    end
  end

  assign addressed = perf_en && (device == DEV_ID);
  assign is_sw     = addressed && (command == READ_SW);
  assign is_btn    = addressed && (command == READ_BTN);
  assign is_evt    = addressed && (command == READ_EVT);

  // a rise landing on the clearing edge survives the clear
  assign rise     = stable_next[12:8] & ~stable[12:8];
  assign evt_next = (evt & ~{5{is_evt}}) | rise;

  always_comb begin
    rd_data = data_out;
    hit     = 1'b1;
    unique case (1'b1)
      is_sw:   rd_data = {24'd0, stable[7:0]};
      is_btn:  rd_data = {27'd0, stable[12:8]};
      is_evt:  rd_data = {27'd0, evt};
      default: hit = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1         <= '0;
      s2         <= '0;
      stable     <= '0;
      evt        <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      for (int i = 0; i < 13; i++) cnt[i] <= '0;
    end else begin
      s1         <= raw;
      s2         <= s1;
      stable     <= stable_next;
      evt        <= evt_next;
      data_out   <= rd_data;
      data_valid <= hit;
      for (int i = 0; i < 13; i++) cnt[i] <= cnt_next[i];
    end
  end

`ifdef SWITCH_BUTTONS_IRQ_EN
  always_ff @(posedge clk) begin
    if (!reset) irq <= 1'b0;
    else        irq <= |evt;
  end
`endif

endmodule

// File: tb/tb_switch_buttons_in.sv
// Bench for switch_buttons_in: directed scenarios plus random traffic
// checked every cycle against a window-based reference model.
module tb_switch_buttons_in;

  localparam int D = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        perf_en = 1'b0;
  logic [4:0]  device = '0;
  logic [5:0]  command = '0;
  logic [7:0]  switches = '0;
  logic [4:0]  buttons = '0;
  logic [31:0] data_out;
  logic        data_valid;
`ifdef SWITCH_BUTTONS_IRQ_EN
  logic        irq;
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  switch_buttons_in #(
    .DEV_ID(5'b00001),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk(clk),
    .reset(reset),
    .perf_en(perf_en),
    .device(device),
    .command(command),
    .switches(switches),
    .buttons(buttons),
    .data_out(data_out),
    .data_valid(data_valid)
`ifdef SWITCH_BUTTONS_IRQ_EN
    ,
    .irq(irq)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: raw delayed 2 edges, stable flips once the last D
  // synced samples all disagree with it
  logic [12:0] rq[$];
  logic [12:0] sq[$];
  logic [12:0] m_stable;
  logic [4:0]  m_evt;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_irq;
  bit          live = 0;

  always @(posedge clk) begin : model
    logic [12:0] rw;
    logic [12:0] syn;
    logic [12:0] nxt;
    logic [4:0]  rise;
    bit          hit;
    bit          flip;
    if (!reset) begin
      rq = {13'd0, 13'd0};
      sq.delete();
      m_stable = '0;
      m_evt = '0;
      m_data = '0;
      m_valid = 1'b0;
      m_irq = 1'b0;
      live = 1;
    end else begin
      rw = {buttons, switches};
      syn = rq.pop_front();
      rq.push_back(rw);
      sq.push_back(syn);
      if (sq.size() > D) void'(sq.pop_front());
      nxt = m_stable;
      if (sq.size() == D) begin
        for (int i = 0; i < 13; i++) begin
          flip = 1;
          foreach (sq[j]) if (sq[j][i] == m_stable[i]) flip = 0;
          if (flip) nxt[i] = ~m_stable[i];
        end
      end
      rise = nxt[12:8] & ~m_stable[12:8];
      hit = perf_en && device == 5'b00001 &&
            (command == 6'd2 || command == 6'd3 || command == 6'd4);
      m_irq = |m_evt;
      m_valid = hit;
      if (hit) begin
        case (command)
          6'd2: m_data = {24'd0, m_stable[7:0]};
          6'd3: m_data = {27'd0, m_stable[12:8]};
          default: m_data = {27'd0, m_evt};
        endcase
      end
      if (hit && command == 6'd4) m_evt = '0;
      m_evt = m_evt | rise;
      m_stable = nxt;
    end
  end

  always @(negedge clk) begin
    if (live) begin
      check("model_valid", {31'd0, data_valid}, {31'd0, m_valid});
      check("model_data", data_out, m_data);
`ifdef SWITCH_BUTTONS_IRQ_EN
      check("model_irq", {31'd0, irq}, {31'd0, m_irq});
`endif
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic access(input logic [4:0] dev, input logic [5:0] cmd,
                        input logic pe);
    device = dev;
    command = cmd;
    perf_en = pe;
    @(negedge clk);
    device = '0;
    command = '0;
    perf_en = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    switches = 8'hFF;
    cycles(3);
    check("rst_data", data_out, 32'd0);
    check("rst_valid", {31'd0, data_valid}, 32'd0);
    reset = 1'b1;

    cycles(10);
    access(5'd1, 6'd2, 1'b1);
    check("sw_early", data_out, 32'd0);
    check("sw_early_v", {31'd0, data_valid}, 32'd1);
    cycles(10);
    access(5'd1, 6'd2, 1'b1);
    check("sw_ff", data_out, 32'hFF);

    switches = 8'hA5;
    cycles(20);
    access(5'd1, 6'd2, 1'b1);
    check("sw_a5", data_out, 32'hA5);
    check("sw_a5_v", {31'd0, data_valid}, 32'd1);
    cycles(1);
    check("sw_strobe_once", {31'd0, data_valid}, 32'd0);

    buttons = 5'b00001;
    cycles(10);
    buttons = '0;
    cycles(25);
    access(5'd1, 6'd3, 1'b1);
    check("glitch_btn", data_out, 32'd0);
    access(5'd1, 6'd4, 1'b1);
    check("glitch_evt", data_out, 32'd0);

    buttons = 5'b00100;
    cycles(30);
    buttons = '0;
    cycles(25);
    access(5'd1, 6'd4, 1'b1);
    check("evt_b2", data_out, 32'h4);
    access(5'd1, 6'd4, 1'b1);
    check("evt_cleared", data_out, 32'h0);

    access(5'd1, 6'd2, 1'b0);
    check("gate_pe_v", {31'd0, data_valid}, 32'd0);
    check("gate_pe_d", data_out, 32'd0);
    access(5'd0, 6'd2, 1'b1);
    check("gate_dev_v", {31'd0, data_valid}, 32'd0);
    check("gate_dev_d", data_out, 32'd0);
    access(5'd1, 6'd1, 1'b1);
    check("gate_led_v", {31'd0, data_valid}, 32'd0);
    buttons = 5'b01000;
    cycles(30);
    buttons = '0;
    cycles(25);
`ifdef SWITCH_BUTTONS_IRQ_EN
    check("irq_pending", {31'd0, irq}, 32'd1);
`endif
    access(5'd1, 6'd4, 1'b0);
    check("gate_evt_v", {31'd0, data_valid}, 32'd0);
    access(5'd1, 6'd4, 1'b1);
    check("evt_kept", data_out, 32'h8);

    // press lands so the debounced rise coincides with the read edge
    buttons = 5'b00010;
    cycles(D + 1);
    access(5'd1, 6'd4, 1'b1);
    check("simul_first", data_out, 32'h0);
    check("simul_first_v", {31'd0, data_valid}, 32'd1);
    cycles(3);
`ifdef SWITCH_BUTTONS_IRQ_EN
    check("simul_irq_hi", {31'd0, irq}, 32'd1);
`endif
    access(5'd1, 6'd4, 1'b1);
    check("simul_second", data_out, 32'h2);
    cycles(2);
`ifdef SWITCH_BUTTONS_IRQ_EN
    check("simul_irq_lo", {31'd0, irq}, 32'd0);
`endif
    buttons = '0;
    cycles(25);

    repeat (4000) begin
      if ($urandom_range(0, 19) == 0) switches = 8'($urandom);
      for (int b = 0; b < 5; b++)
        if ($urandom_range(0, 24) == 0) buttons[b] = ~buttons[b];
      perf_en = ($urandom_range(0, 3) != 0);
      device = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd1;
      case ($urandom_range(0, 5))
        0: command = 6'd1;
        1: command = 6'd2;
        2: command = 6'd3;
        3, 4: command = 6'd4;
        default: command = 6'($urandom);
      endcase
      reset = ($urandom_range(0, 999) != 0);
      @(negedge clk);
    end
    reset = 1'b1;
    perf_en = 1'b0;
    cycles(2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
